// File: rtl/ap_dc_pkg.sv
// Shared types and defaults for the data-cache line controller:
// FSM state encoding, default parameter values and the word-to-DDR address helper.
package ap_dc_pkg;

  localparam int DEF_NUM_LINES      = 4;
  localparam int DEF_LINE_DEPTH     = 16;
  localparam int DEF_ADDR_WIDTH_MEM = 16;
  localparam int DEF_DDR_ADDR_WIDTH = 28;
  localparam int DEF_DDR_SHIFT      = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB_REQ,
    WB_DATA,
    RF_REQ,
    RF_DATA,
    RETRY
  } dc_state_t;

  function automatic logic [63:0] ddr_byte_addr(input logic [63:0] word_addr,
                                                input int unsigned shift);
    return word_addr << shift;
  endfunction

endpackage

// File: rtl/dc_tag_array.sv
// Tag/valid (and, with DC_WRITEBACK_EN, dirty) store for the cache lines,
// with a parallel compare of the lookup tag against every valid line.
module dc_tag_array
  import ap_dc_pkg::*;
#(
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int TAG_W     = 12,
  localparam int LINE_W   = $clog2(NUM_LINES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit,
  output logic [LINE_W-1:0] hit_idx,
  input  logic [LINE_W-1:0] wr_idx,
  input  logic              inval_en,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag
`ifdef DC_WRITEBACK_EN
  ,
  input  logic              fill_dirty,
  input  logic              set_dirty,
  output logic [TAG_W-1:0]  victim_tag,
  output logic              victim_wb
`endif
);

  logic [TAG_W-1:0]     tags [NUM_LINES];
  logic [NUM_LINES-1:0] valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else begin
      if (inval_en) valid[wr_idx] <= 1'b0;
      if (fill_en)  valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) tags[wr_idx] <= fill_tag;
  end

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      if (valid[i] && (tags[i] == lookup_tag)) begin
        hit     = 1'b1;
        hit_idx = LINE_W'(i);
      end
    end
  end

`ifdef DC_WRITEBACK_EN
  logic [NUM_LINES-1:0] dirty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dirty <= '0;
    end else if (fill_en) begin
      dirty[wr_idx] <= fill_dirty;
    end else if (set_dirty) begin
      dirty[hit_idx] <= 1'b1;
    end
  end

  assign victim_tag = tags[wr_idx];
  assign victim_wb  = valid[wr_idx] && dirty[wr_idx];
`endif

endmodule

// File: rtl/dc_line_ctrl.sv
// Direct-lookup line controller: parallel tag compare, round-robin victim,
// DDR refill and optional dirty-line writeback (DC_WRITEBACK_EN).
module dc_line_ctrl
  import ap_dc_pkg::*;
#(
  parameter int NUM_LINES      = DEF_NUM_LINES,
  parameter int LINE_DEPTH     = DEF_LINE_DEPTH,
  parameter int ADDR_WIDTH_MEM = DEF_ADDR_WIDTH_MEM,
  parameter int DDR_ADDR_WIDTH = DEF_DDR_ADDR_WIDTH,
  parameter int DDR_SHIFT      = DEF_DDR_SHIFT,
  localparam int LINE_W        = $clog2(NUM_LINES),
  localparam int OFF_W         = $clog2(LINE_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  input  logic [ADDR_WIDTH_MEM-1:0] req_addr,
  input  logic                      req_we,
  output logic                      req_ready,
  output logic                      hit_valid,
  output logic [LINE_W-1:0]         hit_line,
  output logic [OFF_W-1:0]          hit_offset,
  output logic                      ddr_rd_req,
  output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr,
  input  logic                      rd_burst_data_valid,
  output logic                      refill_we,
  output logic [LINE_W-1:0]         refill_line,
  output logic [OFF_W-1:0]          refill_offset,
  output logic                      ddr_wr_req,
  output logic [DDR_ADDR_WIDTH-1:0] ddr_wr_addr,
  output logic                      wb_rd_en,
  output logic [LINE_W-1:0]         wb_line,
  output logic [OFF_W-1:0]          wb_offset,
  input  logic                      ddr_wr_done,
  output logic                      busy
);

  localparam int TAG_W = ADDR_WIDTH_MEM - OFF_W;
  localparam int CNT_W = OFF_W + 1;

  dc_state_t         state, nxt;
  logic [TAG_W-1:0]  rq_tag;
  logic [OFF_W-1:0]  rq_off;
  logic [LINE_W-1:0] ptr;
  logic [CNT_W-1:0]  cnt;
  logic              accept, last_beat, hit;
  logic [LINE_W-1:0] hit_idx;

  assign accept    = req_valid && (state == IDLE);
  assign last_beat = rd_burst_data_valid && (cnt == CNT_W'(LINE_DEPTH - 1));

`ifdef DC_WRITEBACK_EN
  logic             rq_we, victim_wb;
  logic [TAG_W-1:0] victim_tag;
`else
  logic unused_wb_inputs;
  assign unused_wb_inputs = ddr_wr_done ^ req_we;
`endif

  dc_tag_array #(
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W)
  ) u_tags (
    .clk        (clk),
    .rst        (rst),
    .lookup_tag (rq_tag),
    .hit        (hit),
    .hit_idx    (hit_idx),
    .wr_idx     (ptr),
    .inval_en   (state == RF_REQ),
    .fill_en    ((state == RF_DATA) && last_beat),
    .fill_tag   (rq_tag)
`ifdef DC_WRITEBACK_EN
    ,
    .fill_dirty (rq_we),
    .set_dirty  ((state == LOOKUP) && hit && rq_we),
    .victim_tag (victim_tag),
    .victim_wb  (victim_wb)
`endif
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = LOOKUP;
      LOOKUP: begin
        if (hit) nxt = IDLE;
`ifdef DC_WRITEBACK_EN
        else if (victim_wb) nxt = WB_REQ;
`endif
        else nxt = RF_REQ;
      end
`ifdef DC_WRITEBACK_EN
      WB_REQ:  nxt = WB_DATA;
      WB_DATA: if (ddr_wr_done && (cnt == CNT_W'(LINE_DEPTH))) nxt = RF_REQ;
`endif
      RF_REQ:  nxt = RF_DATA;
      RF_DATA: if (last_beat) nxt = RETRY;
      RETRY:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // cnt is shared: beat index during refill, strobe index during writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rq_tag <= '0;
      rq_off <= '0;
      ptr    <= '0;
      cnt    <= '0;
`ifdef DC_WRITEBACK_EN
      rq_we  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        rq_tag <= req_addr[ADDR_WIDTH_MEM-1:OFF_W];
        rq_off <= req_addr[OFF_W-1:0];
`ifdef DC_WRITEBACK_EN
        rq_we  <= req_we;
`endif
      end
      case (state)
`ifdef DC_WRITEBACK_EN
        WB_DATA: begin
          if (cnt != CNT_W'(LINE_DEPTH)) cnt <= cnt + 1'b1;
          else if (ddr_wr_done)          cnt <= '0;
        end
`endif
        RF_DATA: if (rd_burst_data_valid) cnt <= last_beat ? '0 : cnt + 1'b1;
        RETRY:   ptr <= ptr + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    req_ready     = (state == IDLE);
    busy          = (state != IDLE);
    hit_valid     = 1'b0;
    hit_line      = '0;
    hit_offset    = '0;
    ddr_rd_req    = 1'b0;
    ddr_rd_addr   = '0;
    refill_we     = 1'b0;
    refill_line   = '0;
    refill_offset = '0;
    ddr_wr_req    = 1'b0;
    ddr_wr_addr   = '0;
    wb_rd_en      = 1'b0;
    wb_line       = '0;
    wb_offset     = '0;
    case (state)
      LOOKUP: begin
        if (hit) begin
          hit_valid  = 1'b1;
          hit_line   = hit_idx;
          hit_offset = rq_off;
        end
      end
`ifdef DC_WRITEBACK_EN
      WB_REQ: begin
        ddr_wr_req  = 1'b1;
        ddr_wr_addr = DDR_ADDR_WIDTH'(ddr_byte_addr(64'({victim_tag, {OFF_W{1'b0}}}), DDR_SHIFT));
      end
      WB_DATA: begin
        wb_rd_en  = (cnt != CNT_W'(LINE_DEPTH));
        wb_line   = ptr;
        wb_offset = cnt[OFF_W-1:0];
      end
`endif
      RF_REQ: begin
        ddr_rd_req  = 1'b1;
        ddr_rd_addr = DDR_ADDR_WIDTH'(ddr_byte_addr(64'({rq_tag, {OFF_W{1'b0}}}), DDR_SHIFT));
      end
      RF_DATA: begin
        refill_we     = rd_burst_data_valid;
        refill_line   = ptr;
        refill_offset = cnt[OFF_W-1:0];
      end
      RETRY: begin
        hit_valid  = 1'b1;
        hit_line   = ptr;
        hit_offset = rq_off;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/dc_line_ctrl.md
DC_LINE_CTRL -- requirements
Module: dc_line_ctrl

Interface
REQ-001 SHALL have parameter NUM_LINES, default 4, meaning number of cache lines (power of 2, >=2).
REQ-002 SHALL have parameter LINE_DEPTH, default 16, meaning words per line (power of 2).
REQ-003 SHALL have parameter ADDR_WIDTH_MEM, default 16, meaning word address width.
REQ-004 SHALL have parameter DDR_ADDR_WIDTH, default 28, meaning DDR byte address width.
REQ-005 SHALL have parameter DDR_SHIFT, default 3, meaning word-to-DDR address left shift.
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 reset, asynchronous, active-low.
REQ-007 SHALL have ports: req_valid in 1 lookup request; req_addr in ADDR_WIDTH_MEM word address; req_we in 1 write access (marks line dirty); req_ready out 1 accepts request.
REQ-008 SHALL have ports: hit_valid out 1 lookup result pulse; hit_line out log2(NUM_LINES) line index; hit_offset out log2(LINE_DEPTH) word offset.
REQ-009 SHALL have ports: ddr_rd_req out 1; ddr_rd_addr out DDR_ADDR_WIDTH; rd_burst_data_valid in 1 refill beat; refill_we out 1; refill_line out log2(NUM_LINES); refill_offset out log2(LINE_DEPTH).
REQ-010 SHALL have ports: ddr_wr_req out 1; ddr_wr_addr out DDR_ADDR_WIDTH; wb_rd_en out 1 line-read strobe; wb_line out log2(NUM_LINES); wb_offset out log2(LINE_DEPTH); ddr_wr_done in 1; busy out 1.

Function
REQ-011 SHALL split req_addr into tag = req_addr >> log2(LINE_DEPTH) and offset = low log2(LINE_DEPTH) bits.
REQ-012 SHALL register request on req_valid && req_ready and compare against all valid tags in parallel; hit_valid pulses exactly 1 cycle later (latency 1) with hit_line/hit_offset.
REQ-013 SHALL on miss select victim by round-robin pointer, advancing pointer by 1 modulo NUM_LINES on each fill (wraps NUM_LINES-1 -> 0).
REQ-014 SHALL implement FSM states IDLE, LOOKUP, WB_REQ, WB_DATA, RF_REQ, RF_DATA, RETRY; IDLE->LOOKUP on accept; LOOKUP->IDLE on hit; LOOKUP->WB_REQ if victim valid and dirty, else RF_REQ; WB_REQ->WB_DATA; WB_DATA->RF_REQ on ddr_wr_done; RF_REQ->RF_DATA; RF_DATA->RETRY after LINE_DEPTH beats; RETRY->IDLE with hit_valid pulse.
REQ-015 SHALL assert ddr_rd_req for one cycle in RF_REQ with ddr_rd_addr = (tag*LINE_DEPTH) << DDR_SHIFT, zero-extended.
REQ-016 SHALL in RF_DATA assert refill_we on each rd_burst_data_valid, refill_offset counting 0..LINE_DEPTH-1; beats arriving outside RF_DATA SHALL be ignored.
REQ-017 SHALL on final beat write victim tag, set valid, clear dirty (dirty set if the replayed request has req_we).
REQ-018 SHALL set dirty bit of hit line when req_we on a hit.
REQ-019 SHALL deassert req_ready in all states except IDLE; busy = !(state==IDLE).
REQ-020 SHALL ignore req_valid while not ready; ddr_wr_done outside WB_DATA SHALL be ignored.

Reset
REQ-021 SHALL on rst low asynchronously clear all valid/dirty bits, pointer, counters, FSM to IDLE; all outputs 0 except req_ready=1.
REQ-022 SHALL on reset mid-refill abandon the fill; the partially filled line remains invalid.

Configuration
REQ-023 SHALL with DC_WRITEBACK_EN defined perform WB_REQ/WB_DATA: one-cycle ddr_wr_req with ddr_wr_addr from victim tag, then wb_rd_en with wb_offset 0..LINE_DEPTH-1, one per cycle, then wait ddr_wr_done.
REQ-024 SHALL without DC_WRITEBACK_EN omit dirty bits and WB states; ddr_wr_req, wb_rd_en, wb_line, wb_offset tied 0.

Structure
REQ-025 SHALL place FSM state enum, DDR address shift helper and default parameter constants in shared package ap_dc_pkg.
REQ-026 SHALL implement tag store plus parallel compare as sub-module dc_tag_array; FSM and counters in dc_line_ctrl.

Verification
REQ-027 SHALL cover cold miss: req_addr=0x0025 -> ddr_rd_req with ddr_rd_addr=0x100, 16 refill_we beats line 0, then hit_valid line 0 offset 5.
REQ-028 SHALL cover hit: repeat 0x0027 after fill -> hit_valid one cycle after accept, line 0 offset 7, no DDR request.
REQ-029 SHALL cover wrap: fill tags 0..4 sequentially -> fifth fill evicts line 0, pointer returns to 1.
REQ-030 SHALL cover writeback (DC_WRITEBACK_EN): write hit 0x0003, then evict line 0 -> ddr_wr_addr=0x000, 16 wb_rd_en strobes, refill only after ddr_wr_done.
REQ-031 SHALL cover reset after 8 refill beats -> all outputs reset, subsequent req to same tag misses.
REQ-032 SHALL cover stray rd_burst_data_valid and req_valid during busy -> no refill_we, no state change.
